// File: rtl/sync_fifo_chain_pkg.sv
// rtl/sync_fifo_chain_pkg.sv - shared constants and helpers for the sync FIFO chain
//
// Purpose: default word width and depth, plus the level-field width derivation
//          used by sync_fifo_chain and its storage sub-module.
// Ports:   none (package)
package sync_fifo_chain_pkg;

  localparam int DEF_W = 16;
  localparam int DEF_D = 8;

  // Level/threshold fields must represent 0..D inclusive, hence D+1 codes.
  function automatic int fifo_lw(input int d);
    return $clog2(d + 1);
  endfunction

  localparam int DEF_LW = fifo_lw(DEF_D);

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - D x W storage with registered write and asynchronous read
//
// Purpose: FIFO word storage. The asynchronous read port gives the control
//          block first-word-fall-through behaviour straight from the read pointer.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write word
//   i_raddr  in   read address
//   o_rdata  out  word at i_raddr (combinational)
module sync_fifo_ram #(
  parameter int W  = 16,
  parameter int D  = 8,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [D];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_chain.sv
// rtl/sync_fifo_chain.sv - synchronous FWFT FIFO with level, thresholds and sticky error flags
//
// Purpose: single-clock FIFO. Pointers, level and flags live here; words live
//          in sync_fifo_ram.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   flush          synchronous clear of pointers, level and sticky flags
//   w_trigger      write request; w_data is the word to store
//   w_ready        space available (level != D)
//   r_trigger      pop request
//   r_data         head word, valid while r_ready
//   r_ready        head word valid (level != 0)
//   w_thresh_lvl   free-word threshold; w_thresh = free >= w_thresh_lvl
//   r_thresh_lvl   stored-word threshold; r_thresh = level >= r_thresh_lvl
//   level          stored word count 0..D
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
module sync_fifo_chain
  import sync_fifo_chain_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int D  = DEF_D,
  parameter int LW = fifo_lw(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          w_trigger,
  input  logic [W-1:0]  w_data,
  output logic          w_ready,
  input  logic          r_trigger,
  output logic [W-1:0]  r_data,
  output logic          r_ready,
  input  logic [LW-1:0] w_thresh_lvl,
  input  logic [LW-1:0] r_thresh_lvl,
  output logic          w_thresh,
  output logic          r_thresh,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          underflow
);

  localparam int AW = $clog2(D);
  localparam logic [LW-1:0] FULL_LVL = LW'(D);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          r_underflow;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ram_we;

  assign w_ready  = (r_level != FULL_LVL);
  assign r_ready  = (r_level != '0);
  assign w_wr_acc = w_trigger && w_ready;
  assign w_rd_acc = r_trigger && r_ready;
  // Writes dropped by flush/rst must not touch storage either.
  assign w_ram_we = w_wr_acc && !flush && !rst;

  // D is a power of two, so the AW-bit pointers wrap modulo D for free.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      if (w_wr_acc && !w_rd_acc) begin
        r_level <= r_level + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_level <= r_level - 1'b1;
      end
      if (w_trigger && !w_ready) r_overflow  <= 1'b1;
      if (r_trigger && !r_ready) r_underflow <= 1'b1;
    end
  end

  sync_fifo_ram #(
    .W  (W),
    .D  (D),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wptr),
    .i_wdata (w_data),
    .i_raddr (r_rptr),
    .o_rdata (r_data)
  );

  // level never exceeds D, so the free-count subtraction cannot wrap.
  assign w_thresh  = ((FULL_LVL - r_level) >= w_thresh_lvl);
  assign r_thresh  = (r_level >= r_thresh_lvl);
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo_chain.sv
// tb/tb_sync_fifo_chain.sv - directed self-checking bench for sync_fifo_chain
module tb_sync_fifo_chain;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          w_trigger;
  logic [W-1:0]  w_data;
  logic          w_ready;
  logic          r_trigger;
  logic [W-1:0]  r_data;
  logic          r_ready;
  logic [LW-1:0] w_thresh_lvl;
  logic [LW-1:0] r_thresh_lvl;
  logic          w_thresh;
  logic          r_thresh;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_chain #(.W(W), .D(D), .LW(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .w_trigger    (w_trigger),
    .w_data       (w_data),
    .w_ready      (w_ready),
    .r_trigger    (r_trigger),
    .r_data       (r_data),
    .r_ready      (r_ready),
    .w_thresh_lvl (w_thresh_lvl),
    .r_thresh_lvl (r_thresh_lvl),
    .w_thresh     (w_thresh),
    .r_thresh     (r_thresh),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    w_trigger = 1'b1;
    w_data    = d;
    step();
    w_trigger = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; w_trigger = 1'b0; r_trigger = 1'b0;
    w_data = '0; w_thresh_lvl = '0; r_thresh_lvl = '0;
    step();
    rst = 1'b0;

    // Reset state
    check("rst_level", 32'(level), 0);
    check("rst_w_ready", 32'(w_ready), 1);
    check("rst_r_ready", 32'(r_ready), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_w_thresh_0", 32'(w_thresh), 1);
    check("rst_r_thresh_0", 32'(r_thresh), 1);
    r_thresh_lvl = 4'd1; w_thresh_lvl = 4'd9;
    #1;
    check("rst_r_thresh_1", 32'(r_thresh), 0);
    check("rst_w_thresh_9", 32'(w_thresh), 0);
    w_thresh_lvl = 4'd8;
    #1;
    check("rst_w_thresh_8", 32'(w_thresh), 1);
    r_thresh_lvl = '0; w_thresh_lvl = '0;

    // Fill 0x0001..0x0008, then drain in order
    for (int i = 1; i <= 8; i++) push(16'(i));
    check("fill_level", 32'(level), 8);
    check("fill_w_ready", 32'(w_ready), 0);
    check("fill_r_ready", 32'(r_ready), 1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", 32'(r_data), 32'(i));
      r_trigger = 1'b1;
      step();
    end
    r_trigger = 1'b0;
    check("drain_r_ready", 32'(r_ready), 0);
    check("drain_level", 32'(level), 0);
    check("drain_underflow", 32'(underflow), 0);

    // One-cycle write-to-read latency
    push(16'hA5A5);
    check("lat_r_ready", 32'(r_ready), 1);
    check("lat_r_data", 32'(r_data), 32'hA5A5);
    check("lat_level", 32'(level), 1);
    r_trigger = 1'b1; step(); r_trigger = 1'b0;
    check("lat_empty", 32'(level), 0);

    // Steady state at level 4 with simultaneous read/write, pointers wrap
    for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i));
    for (int i = 0; i < 20; i++) begin
      check("rw_data", 32'(r_data), 32'h0100 + 32'(i));
      w_trigger = 1'b1; r_trigger = 1'b1; w_data = 16'h0104 + 16'(i);
      step();
      check("rw_level", 32'(level), 4);
    end
    w_trigger = 1'b0;
    for (int i = 20; i < 24; i++) begin
      check("rw_tail_data", 32'(r_data), 32'h0100 + 32'(i));
      step();
    end
    r_trigger = 1'b0;
    check("rw_end_level", 32'(level), 0);

    // Thresholds r=3, w=6 while filling 0..3
    r_thresh_lvl = 4'd3; w_thresh_lvl = 4'd6;
    #1;
    check("th_l0_r", 32'(r_thresh), 0);
    check("th_l0_w", 32'(w_thresh), 1);
    push(16'h0011);
    check("th_l1_r", 32'(r_thresh), 0);
    check("th_l1_w", 32'(w_thresh), 1);
    push(16'h0012);
    check("th_l2_r", 32'(r_thresh), 0);
    check("th_l2_w", 32'(w_thresh), 1);
    push(16'h0013);
    check("th_l3_r", 32'(r_thresh), 1);
    check("th_l3_w", 32'(w_thresh), 0);
    r_thresh_lvl = '0; w_thresh_lvl = '0;
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_level", 32'(level), 0);

    // Overflow keeps contents, underflow, flush beats a write
    for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i));
    push(16'hDEAD);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_level", 32'(level), 8);
    for (int i = 0; i < 8; i++) begin
      check("ovf_data", 32'(r_data), 32'h0200 + 32'(i));
      r_trigger = 1'b1;
      step();
    end
    check("ovf_sticky", 32'(overflow), 1);
    check("udf_pre", 32'(underflow), 0);
    step();
    r_trigger = 1'b0;
    check("udf_flag", 32'(underflow), 1);
    check("udf_level", 32'(level), 0);
    flush = 1'b1; w_trigger = 1'b1; w_data = 16'hBEEF;
    step();
    flush = 1'b0; w_trigger = 1'b0;
    check("fl_level", 32'(level), 0);
    check("fl_overflow", 32'(overflow), 0);
    check("fl_underflow", 32'(underflow), 0);
    check("fl_r_ready", 32'(r_ready), 0);

    // Reset beats simultaneous read/write at level 5
    for (int i = 0; i < 5; i++) push(16'h0300 + 16'(i));
    check("rs_pre_level", 32'(level), 5);
    rst = 1'b1; r_trigger = 1'b1; w_trigger = 1'b1; w_data = 16'h0777;
    step();
    rst = 1'b0; r_trigger = 1'b0; w_trigger = 1'b0;
    check("rs_level", 32'(level), 0);
    check("rs_r_ready", 32'(r_ready), 0);
    check("rs_w_ready", 32'(w_ready), 1);
    check("rs_overflow", 32'(overflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
